// File: rtl/ula_issue_ctrl.sv
// ula_issue_ctrl: multi-cycle RV32 issue controller for the ALU datapath.
// Accepts one instruction per valid/ready handshake and walks it through
// IDLE -> DECODE -> EXEC -> WB. It drives the ALU operation code, the
// immediate and the operand select during EXEC, samples the ALU zero flag
// at the end of EXEC to resolve BEQ/BNE, and pulses the completion outputs
// in WB.
// Optional feature macro: ULA_MUL_EN. When it is defined, R-type funct7
// 0000001 / funct3 000 decodes to MUL. When it is undefined, that encoding
// is illegal and ALU code 0110 is never driven.
module ula_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [3:0]  ula_control,
  output logic        alu_src_imm,
  output logic [31:0] imm,
  input  logic        zero_flag,
  output logic        reg_write,
  output logic        branch_taken,
  output logic        illegal,
  output logic        done
);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;
`ifdef ULA_MUL_EN
  localparam logic [6:0] F7_MUL  = 7'b0000001;
  localparam logic [3:0] ALU_MUL = 4'b0110;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] instr_r;
  logic        legal_r;
  logic        is_branch_r;
  logic        is_bne_r;

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_b_s;

  logic        dec_legal_s;
  logic        dec_branch_s;
  logic        dec_bne_s;
  logic [3:0]  raw_code_s;
  logic        raw_src_imm_s;
  logic [31:0] raw_imm_s;
  logic [3:0]  dec_code_s;
  logic        dec_src_imm_s;
  logic [31:0] dec_imm_s;

  assign opcode_s = instr_r[6:0];
  assign funct3_s = instr_r[14:12];
  assign funct7_s = instr_r[31:25];
  assign imm_i_s  = {{20{instr_r[31]}}, instr_r[31:20]};
  assign imm_b_s  = {{19{instr_r[31]}}, instr_r[31], instr_r[7],
                     instr_r[30:25], instr_r[11:8], 1'b0};

  // Register addresses come straight from the latched instruction word.
  assign rs1_addr = instr_r[19:15];
  assign rs2_addr = instr_r[24:20];
  assign rd_addr  = instr_r[11:7];

  // Only IDLE can take a new instruction.
  assign instr_ready = (state_r == S_IDLE);

  // Decode the latched instruction into legality, branch kind and ALU controls.
  always_comb begin
    dec_legal_s   = 1'b0;
    dec_branch_s  = 1'b0;
    dec_bne_s     = 1'b0;
    raw_code_s    = ALU_AND;
    raw_src_imm_s = 1'b0;
    raw_imm_s     = 32'd0;
    case (opcode_s)
      OP_R: begin
        case ({funct7_s, funct3_s})
          {F7_BASE, 3'b000}: begin dec_legal_s = 1'b1; raw_code_s = ALU_ADD; end
          {F7_BASE, 3'b001}: begin dec_legal_s = 1'b1; raw_code_s = ALU_SLL; end
          {F7_BASE, 3'b010}: begin dec_legal_s = 1'b1; raw_code_s = ALU_SLT; end
          {F7_BASE, 3'b100}: begin dec_legal_s = 1'b1; raw_code_s = ALU_XOR; end
          {F7_BASE, 3'b101}: begin dec_legal_s = 1'b1; raw_code_s = ALU_SRL; end
          {F7_BASE, 3'b110}: begin dec_legal_s = 1'b1; raw_code_s = ALU_OR;  end
          {F7_BASE, 3'b111}: begin dec_legal_s = 1'b1; raw_code_s = ALU_AND; end
          {F7_ALT,  3'b000}: begin dec_legal_s = 1'b1; raw_code_s = ALU_SUB; end
`ifdef ULA_MUL_EN
          {F7_MUL,  3'b000}: begin dec_legal_s = 1'b1; raw_code_s = ALU_MUL; end
`endif
          default:           dec_legal_s = 1'b0;
        endcase
      end
      OP_I: begin
        raw_src_imm_s = 1'b1;
        raw_imm_s     = imm_i_s;
        case (funct3_s)
          3'b000: begin dec_legal_s = 1'b1; raw_code_s = ALU_ADD; end
          3'b010: begin dec_legal_s = 1'b1; raw_code_s = ALU_SLT; end
          3'b100: begin dec_legal_s = 1'b1; raw_code_s = ALU_XOR; end
          3'b110: begin dec_legal_s = 1'b1; raw_code_s = ALU_OR;  end
          3'b111: begin dec_legal_s = 1'b1; raw_code_s = ALU_AND; end
          3'b001: begin
            dec_legal_s = (funct7_s == F7_BASE);
            raw_code_s  = ALU_SLL;
          end
          3'b101: begin
            dec_legal_s = (funct7_s == F7_BASE);
            raw_code_s  = ALU_SRL;
          end
          default: dec_legal_s = 1'b0;
        endcase
      end
      OP_B: begin
        raw_code_s = ALU_SUB;
        raw_imm_s  = imm_b_s;
        case (funct3_s)
          3'b000: begin dec_legal_s = 1'b1; dec_branch_s = 1'b1; end
          3'b001: begin dec_legal_s = 1'b1; dec_branch_s = 1'b1; dec_bne_s = 1'b1; end
          default: dec_legal_s = 1'b0;
        endcase
      end
      default: dec_legal_s = 1'b0;
    endcase
  end

  // Illegal encodings present neutral ALU controls during EXEC.
  assign dec_code_s    = dec_legal_s ? raw_code_s    : ALU_AND;
  assign dec_src_imm_s = dec_legal_s ? raw_src_imm_s : 1'b0;
  assign dec_imm_s     = dec_legal_s ? raw_imm_s     : 32'd0;

  // Issue FSM with registered ALU controls and one-cycle completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      instr_r      <= 32'd0;
      legal_r      <= 1'b0;
      is_branch_r  <= 1'b0;
      is_bne_r     <= 1'b0;
      ula_control  <= 4'b0000;
      alu_src_imm  <= 1'b0;
      imm          <= 32'd0;
      reg_write    <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      done         <= 1'b0;
    end else begin
      reg_write    <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      done         <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (instr_valid) begin
            instr_r <= instr;
            state_r <= S_DECODE;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_DECODE: begin
          legal_r     <= dec_legal_s;
          is_branch_r <= dec_branch_s;
          is_bne_r    <= dec_bne_s;
          ula_control <= dec_code_s;
          alu_src_imm <= dec_src_imm_s;
          imm         <= dec_imm_s;
          state_r     <= S_EXEC;
        end
        S_EXEC: begin
          // zero_flag reflects the ALU result for the code driven this cycle.
          ula_control <= 4'b0000;
          done        <= 1'b1;
          if (!legal_r) begin
            illegal <= 1'b1;
          end else if (is_branch_r) begin
            branch_taken <= is_bne_r ? ~zero_flag : zero_flag;
          end else begin
            reg_write <= 1'b1;
          end
          state_r <= S_WB;
        end
        S_WB: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r     <= S_IDLE;
          ula_control <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_issue_ctrl.sv
// Randomized scoreboard bench for ula_issue_ctrl. A table of legal
// mask/match encodings serves as the reference decoder; the driver pushes
// expectations at each handshake and a negedge monitor checks EXEC and WB.
module tb_ula_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [3:0]  ula_control;
  logic        alu_src_imm;
  logic [31:0] imm;
  logic        zero_flag;
  logic        reg_write;
  logic        branch_taken;
  logic        illegal;
  logic        done;

  ula_issue_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .ula_control(ula_control), .alu_src_imm(alu_src_imm), .imm(imm),
    .zero_flag(zero_flag), .reg_write(reg_write), .branch_taken(branch_taken),
    .illegal(illegal), .done(done)
  );

`ifdef ULA_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] w;
    int          due;
    logic        legal;
    logic        br;
    logic        bne;
    logic        has_imm;
    logic [3:0]  code;
    logic        src;
    logic [31:0] imm;
    logic        zf;
  } exp_t;

  // Legal encodings: kind 0 = R, 1 = I, 2 = BEQ, 3 = BNE.
  localparam int NTBL = 18;
  logic [31:0] tbl_mask  [0:NTBL-1] = '{
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
    32'hFE00707F, 32'hFE00707F, 32'h0000707F, 32'h0000707F};
  logic [31:0] tbl_match [0:NTBL-1] = '{
    32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00004033,
    32'h00005033, 32'h00006033, 32'h00007033, 32'h02000033,
    32'h00000013, 32'h00002013, 32'h00004013, 32'h00006013, 32'h00007013,
    32'h00001013, 32'h00005013, 32'h00000063, 32'h00001063};
  logic [3:0]  tbl_code  [0:NTBL-1] = '{
    4'd2, 4'd4, 4'd3, 4'd8, 4'd7, 4'd5, 4'd1, 4'd0, 4'd6,
    4'd2, 4'd8, 4'd7, 4'd1, 4'd0, 4'd3, 4'd5, 4'd4, 4'd4};
  int          tbl_kind  [0:NTBL-1] = '{
    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 2, 3};

  exp_t exec_q[$];
  exp_t wb_q[$];
  exp_t e_mon;
  int   cyc = 0;
  int   hs_cyc = -100;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [31:0] w);
    exp_t r;
    int   v;
    r.w = w; r.due = 0; r.legal = 1'b0; r.br = 1'b0; r.bne = 1'b0;
    r.has_imm = 1'b0; r.code = 4'd0; r.src = 1'b0; r.imm = 32'd0; r.zf = 1'b0;
    for (int i = 0; i < NTBL; i++) begin
      if (((w & tbl_mask[i]) == tbl_match[i]) && !(i == 8 && !MUL_EN)) begin
        r.legal = 1'b1;
        r.code  = tbl_code[i];
        if (tbl_kind[i] == 1) begin
          r.src = 1'b1; r.has_imm = 1'b1;
          v = $signed(w) >>> 20;
          r.imm = 32'(v);
        end else if (tbl_kind[i] >= 2) begin
          r.br = 1'b1; r.bne = (tbl_kind[i] == 3); r.has_imm = 1'b1;
          v = w[31] ? -4096 : 0;
          v = v + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
          r.imm = 32'(v);
        end
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0, 1:    w[31:25] = 7'h00;
          2:       w[31:25] = 7'h20;
          default: w[31:25] = 7'h01;
        endcase
      end
      3, 4, 5: begin
        w[6:0] = 7'h13;
        if ($urandom_range(0, 1) == 1) w[31:25] = 7'h00;
      end
      6, 7: begin
        w[6:0] = 7'h63;
        w[14:12] = 3'($urandom_range(0, 2));
      end
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one instruction and wait (bounded) for its handshake.
  task automatic send(input logic [31:0] w, input bit hold);
    exp_t e;
    int   n;
    n = 0;
    instr = w;
    instr_valid = 1'b1;
    @(negedge clk); #1;
    while (!instr_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (!instr_ready) begin
      chk("handshake_timeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      return;
    end
    e = model(w);
    e.due = cyc + 2;
    exec_q.push_back(e);
    hs_cyc = cyc;
    @(posedge clk); #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    zero_flag = 1'b0;
    forever begin
      @(posedge clk); #1;
      zero_flag = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: EXEC controls, WB pulses and ready spacing, sampled at negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (exec_q.size() > 0 && exec_q[0].due == cyc) begin
        e_mon = exec_q.pop_front();
        if (e_mon.legal) begin
          chk("exec_code", 32'(ula_control), 32'(e_mon.code));
          chk("exec_src", 32'(alu_src_imm), 32'(e_mon.src));
          if (e_mon.has_imm) chk("exec_imm", imm, e_mon.imm);
        end else begin
          chk("exec_illegal_not_mul", 32'(ula_control != 4'b0110), 32'd1);
        end
        chk("exec_rs1", 32'(rs1_addr), 32'(e_mon.w[19:15]));
        chk("exec_rs2", 32'(rs2_addr), 32'(e_mon.w[24:20]));
        e_mon.zf = zero_flag;
        wb_q.push_back(e_mon);
      end else begin
        chk("code_outside_exec", 32'(ula_control), 32'd0);
      end
      if (wb_q.size() > 0 && wb_q[0].due + 1 == cyc) begin
        e_mon = wb_q.pop_front();
        chk("wb_done", 32'(done), 32'd1);
        chk("wb_reg_write", 32'(reg_write), 32'(e_mon.legal && !e_mon.br));
        chk("wb_branch", 32'(branch_taken),
            32'(e_mon.legal && e_mon.br && (e_mon.bne ? !e_mon.zf : e_mon.zf)));
        chk("wb_illegal", 32'(illegal), 32'(!e_mon.legal));
        chk("wb_rd", 32'(rd_addr), 32'(e_mon.w[11:7]));
      end else begin
        chk("quiet_pulses", {28'd0, done, reg_write, branch_taken, illegal}, 32'd0);
      end
      if (cyc - hs_cyc >= 1 && cyc - hs_cyc <= 3) chk("ready_busy", 32'(instr_ready), 32'd0);
      if (cyc - hs_cyc == 4) chk("ready_again", 32'(instr_ready), 32'd1);
    end
  end

  // Stimulus: reset, directed test-plan vectors, reset abort, back-to-back, random.
  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_code", 32'(ula_control), 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_addrs", {17'd0, rs1_addr, rs2_addr, rd_addr}, 32'd0);
    chk("rst_pulses", {27'd0, alu_src_imm, done, reg_write, branch_taken, illegal}, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    send(32'h002081B3, 1'b0);
    send(32'hFFF00293, 1'b0);
    for (int i = 0; i < 4; i++) send(32'h00208463, 1'b0);
    send(32'h00209463, 1'b0);
    send(32'h022081B3, 1'b0);
    send(32'h4010D093, 1'b0);
    send(32'h4020D0B3, 1'b0);
    send(32'h0000A083, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Abort an ADD in EXEC: it must vanish without any WB pulse.
    send(32'h002081B3, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exec_q.delete();
    wb_q.delete();
    hs_cyc = -100;
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_code", 32'(ula_control), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (5) @(posedge clk);
    #1;

    // instr_valid held high across three ADDs.
    send(32'h002081B3, 1'b1);
    send(32'h00418233, 1'b1);
    send(32'h006282B3, 1'b0);

    for (int i = 0; i < 300; i++) begin
      send(rand_instr(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        instr_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    instr_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exec_q.size() + wb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_issue_ctrl.md
# ula_issue_ctrl

Multi-cycle issue controller that drives the ALU's operation-select input and consumes its zero flag. It accepts one RV32 instruction at a time over a valid/ready handshake and decodes it to a 4-bit ALU code, an immediate and an operand select. It samples the ALU zero flag to resolve BEQ/BNE and reports completion with register-write or branch outcome. It sits between instruction fetch and the ALU/register-file datapath.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- instr_valid  input  1  instr holds a valid instruction
- instr_ready  output  1  controller can accept an instruction
- instr  input  32  RV32 instruction word
- rs1_addr  output  5  instr[19:15] of the latched instruction
- rs2_addr  output  5  instr[24:20] of the latched instruction
- rd_addr  output  5  instr[11:7] of the latched instruction
- ula_control  output  4  ALU operation code
- alu_src_imm  output  1  1 = ALU in2 takes imm; 0 = rs2 data
- imm  output  32  sign-extended I- or B-immediate
- zero_flag  input  1  ALU zero flag (combinational from ALU)
- reg_write  output  1  one-cycle write-enable pulse for rd
- branch_taken  output  1  one-cycle pulse, resolved branch taken
- illegal  output  1  one-cycle pulse, unsupported encoding
- done  output  1  one-cycle pulse, instruction retired

## Operation
- Clock is `clk`. Reset is `rst`, synchronous and active-high.
- FSM states: IDLE, DECODE, EXEC, WB.
  - IDLE -> DECODE on instr_valid && instr_ready.
  - DECODE -> EXEC unconditionally.
  - EXEC -> WB unconditionally.
  - WB -> IDLE unconditionally.
- instr_ready = (state == IDLE). The instruction is latched on the handshake edge. instr is ignored in all other states.
- ALU codes:
  - AND 0000, OR 0001, ADD 0010, SLL 0011, SUB 0100, SRL 0101, MUL 0110, XOR 0111, SLT 1000.
- R-type (opcode 0110011), funct7 0000000:
  - funct3 000 ADD, 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7 0100000 with funct3 000 -> SUB.
  - alu_src_imm = 0.
- I-type (opcode 0010011):
  - ADDI, SLTI, XORI, ORI, ANDI map to ADD/SLT/XOR/OR/AND.
  - SLLI and SRLI require instr[31:25] = 0000000.
  - alu_src_imm = 1. imm = sign-extended instr[31:20].
- Branch (opcode 1100011):
  - funct3 000 BEQ, 001 BNE.
  - ula_control = SUB, alu_src_imm = 0.
  - imm = sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- Every other encoding is illegal: SRA/SRAI, SLTU/SLTIU, loads, stores, other branches, and unmatched funct7.
- Outputs during EXEC: ula_control, alu_src_imm and imm are valid. ula_control = 0000 outside EXEC.
- zero_flag is sampled at the edge ending EXEC.
- WB outputs:
  - done = 1.
  - reg_write = 1 for legal R/I-type.
  - branch_taken = zero_flag_sampled for BEQ and !zero_flag_sampled for BNE.
  - For an illegal instruction: illegal = 1, reg_write = 0, branch_taken = 0.
- All outputs except instr_ready are registered.

## Timing
- Handshake at edge T. DECODE occupies T+1, EXEC T+2, WB T+3. instr_ready = 1 again at T+4.
- Throughput is one instruction per 4 cycles. Latency from handshake to done is 3 cycles.
- rs1_addr, rs2_addr and rd_addr are valid from T+1 through WB.
- Reset values:
  - State IDLE, so instr_ready = 1 the cycle after rst is sampled.
  - ula_control = 0000, imm = 0, alu_src_imm = 0.
  - rs1_addr = rs2_addr = rd_addr = 0.
  - reg_write = branch_taken = illegal = done = 0.
- rst asserted in any state:
  - The in-flight instruction is dropped. No done, reg_write or branch_taken is produced.
  - The FSM is in IDLE on the following cycle.
- instr_valid held high continuously: exactly one acceptance per 4 cycles. instr_ready is low in DECODE, EXEC and WB.
- instr_valid deasserted in IDLE: the FSM stays in IDLE and all pulses stay at 0.

## Configuration
- ULA_MUL_EN defined:
  - R-type funct7 0000001 with funct3 000 decodes to MUL (0110) with reg_write in WB.
- ULA_MUL_EN undefined:
  - That encoding is illegal. ALU code 0110 is never driven.

## Test plan
- ADD x3,x1,x2 (0x002081B3) accepted at T:
  - EXEC at T+2 with ula_control = 0010, alu_src_imm = 0.
  - T+3: done = 1, reg_write = 1, rd_addr = 3.
- ADDI x5,x0,-1 (0xFFF00293):
  - EXEC: imm = 0xFFFFFFFF, alu_src_imm = 1, ula_control = 0010.
  - WB: reg_write = 1, rd_addr = 5.
- BEQ x1,x2,+8 (0x00208463):
  - EXEC: ula_control = 0100, imm = 0x00000008.
  - zero_flag = 1 in EXEC -> WB branch_taken = 1, reg_write = 0.
  - Repeat with zero_flag = 0 -> branch_taken = 0.
- MUL x3,x1,x2 (0x022081B3):
  - With ULA_MUL_EN: ula_control = 0110, reg_write = 1.
  - Without ULA_MUL_EN: illegal = 1, done = 1, reg_write = 0.
- rst pulsed during EXEC of 0x002081B3:
  - Next cycle instr_ready = 1, ula_control = 0000.
  - done and reg_write never assert for that instruction.
- instr_valid held high with three back-to-back ADDs:
  - Handshakes at T, T+4, T+8.
  - done pulses at T+3, T+7, T+11.
  - SRAI 0x4010D093 -> illegal = 1.
